// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and output buffer geometry.
package fifo_rd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  localparam int OBUF_DEPTH = 4;
  localparam int OBUF_AW    = 2;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Purpose: 4-entry register FIFO of {last, data} that absorbs the FIFO read latency.
// Latency: push visible on out_valid the next cycle; backpressure: holds the head entry while out_ready is low.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [OBUF_AW:0]      occ
);

  logic [DATA_WIDTH:0]  mem [OBUF_DEPTH];
  logic [OBUF_AW-1:0]   wr_ptr;
  logic [OBUF_AW-1:0]   rd_ptr;
  logic [OBUF_AW:0]     occ_q;
  logic                 pop;

  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign occ       = occ_q;

  // Idle output reads as zero so m_data/m_last are clean outside a transfer.
  assign out_data  = out_valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid ? mem[rd_ptr][DATA_WIDTH]     : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_last, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Purpose: drains BURST_LEN-byte (or flushed partial) bursts from the async FIFO onto a valid/ready stream.
// Latency: start -> first m_valid in 3 cycles; backpressure: reads throttle on buffer occupancy, never on m_ready directly.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LEVEL_WIDTH = 12,
  parameter int BURST_LEN   = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   en,
  input  logic                   flush_req,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   burst_done,
  output logic [CNT_WIDTH-1:0]   burst_cnt
);

  localparam logic [LEVEL_WIDTH-1:0] BURST_LEN_L = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [OBUF_AW+1:0]     RD_LIMIT    = (OBUF_AW+2)'(2);

  rd_state_e              state;
  logic [LEVEL_WIDTH-1:0] remaining;
  logic                   flush_pend;
  logic                   inflight;
  logic                   inflight_last;
  logic [OBUF_AW:0]       obuf_occ;
  logic                   start;
  logic                   rd_issue;
  logic                   last_hs;

  assign start = (state == IDLE) && en &&
                 ((fifo_rd_level >= BURST_LEN_L) || (flush_pend && (fifo_rd_level != '0)));

  // Buffer slots already committed (stored + in flight) must leave room for this read's byte.
  assign rd_issue = (state == BURST) && (remaining != '0) && !fifo_rd_empty &&
                    (({1'b0, obuf_occ} + {{(OBUF_AW+1){1'b0}}, inflight}) <= RD_LIMIT);

  assign fifo_rd_en = rd_issue;
  assign last_hs    = m_valid && m_ready && m_last;
  assign busy       = (state != IDLE);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state         <= IDLE;
      remaining     <= '0;
      flush_pend    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      burst_done    <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && (remaining == LEVEL_WIDTH'(1));
      burst_done    <= last_hs;

      // A request arriving on the start cycle stays pending for the following burst.
      if (flush_req) begin
        flush_pend <= 1'b1;
      end else if (start) begin
        flush_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            remaining <= (fifo_rd_level >= BURST_LEN_L) ? BURST_LEN_L : fifo_rd_level;
            state     <= BURST;
          end
        end
        BURST: begin
          if (rd_issue) begin
            remaining <= remaining - 1'b1;
          end
          if (last_hs) begin
            burst_cnt <= burst_cnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .push_last (inflight_last),
    .out_ready (m_ready),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_last  (m_last),
    .occ       (obuf_occ)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a FIFO model with 1-cycle read latency feeds the DUT, a scoreboard checks the stream.
module tb_fifo_burst_reader;

  logic        rd_clk;
  logic        rd_rst;
  logic        en;
  logic        flush_req;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_empty;
  logic [11:0] fifo_rd_level;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
  logic        burst_done;
  logic [15:0] burst_cnt;

  fifo_burst_reader dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .en            (en),
    .flush_req     (flush_req),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_level (fifo_rd_level),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy),
    .burst_done    (burst_done),
    .burst_cnt     (burst_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fifo_q [$];
  logic [8:0] exp_q  [$];
  logic [7:0] next_byte = 8'h00;

  logic        force_empty = 1'b0;
  logic        rnd_ready   = 1'b0;
  logic        rd_en_d     = 1'b0;
  logic        exp_done    = 1'b0;
  logic [15:0] exp_cnt     = 16'd0;
  logic        prev_stall  = 1'b0;
  logic [7:0]  prev_data   = 8'h00;
  logic        prev_last   = 1'b0;
  int          cyc         = 0;
  int          hs_cnt      = 0;
  int          done_cnt    = 0;
  int          busy_cnt    = 0;
  int          rd_en_cnt   = 0;
  int          last_hs_cyc = 0;
  int          max_occ     = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input int n, input int last_period);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_byte);
      exp_q.push_back({(last_period != 0) && (((i + 1) % last_period) == 0), next_byte});
      next_byte++;
    end
  endtask

  // One clock: apply FIFO model, settle, then check everything sampled for the coming edge.
  task automatic tick();
    logic [8:0] e;
    @(posedge rd_clk);
    #1;
    if (rd_en_d && (fifo_q.size() != 0)) fifo_rd_data = fifo_q.pop_front();
    fifo_rd_empty = force_empty || (fifo_q.size() == 0);
    fifo_rd_level = 12'(fifo_q.size());
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    #1;
    cyc++;
    chk_eq("burst_done", burst_done, exp_done);
    chk_eq("burst_cnt", burst_cnt, exp_cnt);
    if (burst_done) done_cnt++;
    exp_done = 1'b0;
    if (fifo_rd_empty) chk_eq("rd_while_empty", fifo_rd_en, 0);
    if (prev_stall) begin
      chk_eq("stall_valid", m_valid, 1);
      chk_eq("stall_data", m_data, prev_data);
      chk_eq("stall_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      chk_eq("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_eq("m_data", m_data, e[7:0]);
        chk_eq("m_last", m_last, e[8]);
        if (e[8]) begin
          exp_done = 1'b1;
          exp_cnt++;
        end
      end
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    rd_en_d    = fifo_rd_en;
    if (busy) busy_cnt++;
    if (fifo_rd_en) rd_en_cnt++;
    if (int'(dut.obuf_occ) > max_occ) max_occ = int'(dut.obuf_occ);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while ((done_cnt == d0) && (n < budget)) begin
      tick();
      n++;
    end
    chk_eq(tag, n < budget, 1);
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while ((hs_cnt < target) && (n < budget)) begin
      tick();
      n++;
    end
    chk_eq(tag, n < budget, 1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk_eq({pfx, "_rd_en"}, fifo_rd_en, 0);
    chk_eq({pfx, "_m_valid"}, m_valid, 0);
    chk_eq({pfx, "_m_last"}, m_last, 0);
    chk_eq({pfx, "_m_data"}, m_data, 0);
    chk_eq({pfx, "_busy"}, busy, 0);
    chk_eq({pfx, "_burst_done"}, burst_done, 0);
    chk_eq({pfx, "_burst_cnt"}, burst_cnt, 0);
  endtask

  initial begin
    int n;
    int c0;
    int hb;
    int b0;
    int r0;

    rd_rst        = 1'b1;
    en            = 1'b0;
    flush_req     = 1'b0;
    m_ready       = 1'b1;
    fifo_rd_data  = 8'h00;
    fifo_rd_empty = 1'b1;
    fifo_rd_level = 12'd0;

    repeat (3) tick();
    chk_reset_outputs("rst");
    rd_rst = 1'b0;
    en     = 1'b1;
    tick();

    // 1: level steps 0 -> 64, full-rate burst
    push_bytes(64, 64);
    tick();
    n = 0;
    while (!m_valid && (n < 20)) begin
      tick();
      n++;
    end
    chk_eq("t1_first_valid_latency", n, 3);
    c0 = cyc;
    hb = hs_cnt - 1;
    wait_done("t1_done_timeout", 200);
    chk_eq("t1_bytes", hs_cnt - hb, 64);
    chk_eq("t1_back_to_back", last_hs_cyc - c0, 63);
    chk_eq("t1_burst_cnt", burst_cnt, 1);
    chk_eq("t1_idle_after", busy, 0);

    // 2: flushed partial burst, then a sub-threshold level without flush
    push_bytes(10, 10);
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    hb = hs_cnt;
    wait_done("t2_done_timeout", 200);
    chk_eq("t2_bytes", hs_cnt - hb, 10);
    chk_eq("t2_sb_drained", exp_q.size(), 0);
    push_bytes(5, 0);
    b0 = busy_cnt;
    hb = hs_cnt;
    repeat (30) tick();
    chk_eq("t2_no_burst_busy", busy_cnt - b0, 0);
    chk_eq("t2_no_burst_bytes", hs_cnt - hb, 0);

    // 3: random back-pressure over a 64-byte burst (5 leftover + 59 new)
    rnd_ready = 1'b1;
    push_bytes(59, 59);
    hb = hs_cnt;
    wait_done("t3_done_timeout", 3000);
    rnd_ready = 1'b0;
    m_ready   = 1'b1;
    chk_eq("t3_bytes", hs_cnt - hb, 64);
    chk_eq("t3_sb_drained", exp_q.size(), 0);
    chk_eq("t3_occ_le_4", max_occ <= 4, 1);

    // 4: FIFO reports empty for 8 cycles mid-burst
    push_bytes(64, 64);
    hb = hs_cnt;
    wait_hs("t4_hs_timeout", hb + 10, 200);
    force_empty = 1'b1;
    r0 = rd_en_cnt;
    repeat (8) tick();
    chk_eq("t4_no_reads_while_empty", rd_en_cnt - r0, 0);
    chk_eq("t4_still_busy", busy, 1);
    force_empty = 1'b0;
    wait_done("t4_done_timeout", 300);
    chk_eq("t4_bytes", hs_cnt - hb, 64);

    // 5: abrupt reset after byte 20, then a fresh burst
    push_bytes(64, 64);
    hb = hs_cnt;
    wait_hs("t5_hs_timeout", hb + 20, 200);
    rd_rst   = 1'b1;
    exp_cnt  = 16'd0;
    exp_done = 1'b0;
    tick();
    chk_reset_outputs("t5_rst");
    rd_rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    rd_en_d    = 1'b0;
    prev_stall = 1'b0;
    tick();
    push_bytes(64, 64);
    hb = hs_cnt;
    wait_done("t5_done_timeout", 200);
    chk_eq("t5_bytes", hs_cnt - hb, 64);
    chk_eq("t5_burst_cnt", burst_cnt, 1);

    // 6: en gating; dropping en mid-burst completes only the current burst
    en = 1'b0;
    push_bytes(200, 64);
    tick();
    b0 = busy_cnt;
    r0 = rd_en_cnt;
    repeat (20) tick();
    chk_eq("t6_level_seen", fifo_rd_level, 200);
    chk_eq("t6_no_reads_en0", rd_en_cnt - r0, 0);
    chk_eq("t6_no_busy_en0", busy_cnt - b0, 0);
    en = 1'b1;
    hb = hs_cnt;
    wait_hs("t6_hs_timeout", hb + 10, 200);
    en = 1'b0;
    wait_done("t6_done_timeout", 200);
    chk_eq("t6_bytes", hs_cnt - hb, 64);
    b0 = busy_cnt;
    hb = hs_cnt;
    repeat (60) tick();
    chk_eq("t6_no_second_burst", busy_cnt - b0, 0);
    chk_eq("t6_no_extra_bytes", hs_cnt - hb, 0);
    chk_eq("t6_burst_cnt", burst_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
